// File: rtl/bit_4piso_tx_if.sv
// Purpose : Parallel-word / serial-bit bundle between a word producer and the
//           bit_4piso_tx transmitter.
// Signals : D, load           - word and load request (producer -> transmitter)
//           ready, busy       - transmitter status
//           sout, sout_valid  - serial bit and its qualifier
//           done              - pulse on the last bit of a word
// Modports: master = word producer / observer, slave = transmitter.
interface bit_4piso_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             load;
  logic             ready;
  logic             busy;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output D,
    output load,
    input  ready,
    input  busy,
    input  sout,
    input  sout_valid,
    input  done
  );

  modport slave (
    input  D,
    input  load,
    output ready,
    output busy,
    output sout,
    output sout_valid,
    output done
  );
endinterface

// File: rtl/bit_4piso_tx.sv
// Purpose : Parallel-in serial-out transmitter. Captures a WIDTH-bit word on an
//           accepted load and shifts it out one bit per clock, LSB or MSB first.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset, overrides all inputs
//           bus  - bit_4piso_tx_if.slave (D, load in; ready, busy, sout,
//                  sout_valid, done out)
// Params  : WIDTH (>= 2) word width, MSB_FIRST selects shift order.
module bit_4piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  bit_4piso_tx_if.slave  bus
);

  // Reject degenerate widths at elaboration time.
  if (WIDTH < 2) begin : g_width_check
    $error("bit_4piso_tx: WIDTH must be >= 2");
  end

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shreg_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;
  logic             w_out_bit;

  // Output end of the register and zero-filled shift toward it.
  if (MSB_FIRST) begin : g_msb_first
    assign w_out_bit       = r_shreg[WIDTH-1];
    assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_out_bit       = r_shreg[0];
    assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
  end

  assign w_last = (r_state == SHIFT) && (r_cnt == '0);

  // State, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: accept only from IDLE, so a held load always sees one idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = bus.D;
          w_cnt_nxt   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        w_shreg_nxt = w_shreg_shifted;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Flags decoded from registered state only; sout gated to 0 outside SHIFT.
  assign bus.ready      = (r_state == IDLE);
  assign bus.busy       = (r_state == SHIFT);
  assign bus.sout_valid = (r_state == SHIFT);
  assign bus.sout       = (r_state == SHIFT) & w_out_bit;
  assign bus.done       = w_last;

endmodule

// File: tb/tb_bit_4piso_tx.sv
// Purpose : Self-checking bench for bit_4piso_tx. Three instances (4-bit LSB
//           first, 4-bit MSB first, 8-bit LSB first) share clk/rst; a
//           per-instance queue holds the expected bit stream of each accepted
//           word and is consumed one entry per shift cycle.
module tb_bit_4piso_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_4piso_tx_if #(.WIDTH(4)) if0 ();
  bit_4piso_tx_if #(.WIDTH(4)) if1 ();
  bit_4piso_tx_if #(.WIDTH(8)) if2 ();

  bit_4piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bit_4piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bit_4piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // i-th transmitted bit of word d (w bits wide) for the given order.
  function automatic exp_t bit_item(input logic [7:0] d, input int w, input bit msb, input int i);
    exp_t e;
    int   idx;
    idx    = msb ? (w - 1 - i) : i;
    e.b    = d[idx];
    e.last = (i == w - 1);
    return e;
  endfunction

  task automatic check_dut(input string tag, input bit has, input exp_t f,
                           input logic ready, input logic busy, input logic sout,
                           input logic sv, input logic done);
    chk({tag, ".ready"},      ready, !has);
    chk({tag, ".busy"},       busy,  has);
    chk({tag, ".sout_valid"}, sv,    has);
    chk({tag, ".sout"},       sout,  has ? f.b : 1'b0);
    chk({tag, ".done"},       done,  has ? f.last : 1'b0);
  endtask

  // Advance one clock: update the model with the inputs seen at this edge,
  // then check every instance just after the edge.
  task automatic cycle();
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (q0.size() != 0) void'(q0.pop_front());
      else if (if0.load) for (int i = 0; i < 4; i++) q0.push_back(bit_item({4'h0, if0.D}, 4, 1'b0, i));
      if (q1.size() != 0) void'(q1.pop_front());
      else if (if1.load) for (int i = 0; i < 4; i++) q1.push_back(bit_item({4'h0, if1.D}, 4, 1'b1, i));
      if (q2.size() != 0) void'(q2.pop_front());
      else if (if2.load) for (int i = 0; i < 8; i++) q2.push_back(bit_item(if2.D, 8, 1'b0, i));
    end
    @(posedge clk);
    #1;
    check_dut("d0", q0.size() != 0, (q0.size() != 0) ? q0[0] : '0,
              if0.ready, if0.busy, if0.sout, if0.sout_valid, if0.done);
    check_dut("d1", q1.size() != 0, (q1.size() != 0) ? q1[0] : '0,
              if1.ready, if1.busy, if1.sout, if1.sout_valid, if1.done);
    check_dut("d2", q2.size() != 0, (q2.size() != 0) ? q2[0] : '0,
              if2.ready, if2.busy, if2.sout, if2.sout_valid, if2.done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset for two cycles with load asserted and all-ones data.
    rst = 1'b1;
    if0.load = 1'b1; if0.D = 4'hF;
    if1.load = 1'b1; if1.D = 4'hF;
    if2.load = 1'b1; if2.D = 8'hFF;
    run(2);
    rst = 1'b0;
    if0.load = 1'b0; if1.load = 1'b0; if2.load = 1'b0;
    run(3);

    // 4'b1011 on both 4-bit instances (LSB and MSB first), one-cycle load.
    if0.D = 4'b1011; if0.load = 1'b1;
    if1.D = 4'b1011; if1.load = 1'b1;
    cycle();
    if0.load = 1'b0; if1.load = 1'b0;
    if0.D = 4'h0; if1.D = 4'h6;
    run(6);

    // 8-bit word 8'h81.
    if2.D = 8'h81; if2.load = 1'b1;
    cycle();
    if2.load = 1'b0; if2.D = 8'h7E;
    run(10);

    // Held load: 4'hA, then 4'h5 presented during SHIFT.
    if0.D = 4'hA; if0.load = 1'b1;
    cycle();
    if0.D = 4'h5;
    run(6);
    if0.load = 1'b0;
    run(6);

    // Reset during the second bit of 4'hF: transfer aborted, no done.
    if0.D = 4'hF; if0.load = 1'b1;
    if2.D = 8'hFF; if2.load = 1'b1;
    cycle();
    if0.load = 1'b0; if2.load = 1'b0;
    cycle();
    rst = 1'b1; if0.load = 1'b1; if0.D = 4'h3;
    cycle();
    rst = 1'b0; if0.load = 1'b0;
    run(10);

    // Random words on all instances, including back-to-back held loads.
    for (int k = 0; k < 6; k++) begin
      if0.D = 4'($urandom); if1.D = 4'($urandom); if2.D = 8'($urandom);
      if0.load = 1'b1; if1.load = 1'b1; if2.load = 1'b1;
      run(1 + (k % 3) * 5);
      if0.load = 1'b0; if1.load = 1'b0; if2.load = 1'b0;
      run(10);
    end

    chk("q0.drained", q0.size() == 0, 1'b1);
    chk("q1.drained", q1.size() == 0, 1'b1);
    chk("q2.drained", q2.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
